// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
// Performs a WIDTH-bit two's-complement add with a single 4-bit ripple slice.
// The slice is reused over WIDTH/4 cycles, least significant nibble first,
// and the carry is held in a register between nibbles.
// WIDTH must be a multiple of 4 and at least 8.
//
// Optional feature: define NIBBLE_SERIAL_SUB_EN to add a 'sub' input.
// When sub=1 on the accept edge, the block computes a-b: it loads ~b and
// starts with a carry-in of 1. In that mode carryout=1 means no borrow.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid && ready are both 1.
//   start_ready is high only in IDLE. Operands are captured solely on the
//   accept edge.
//   result_valid is high only in DONE. sum and flags stay stable until the
//   consumer takes them (result_ready=1). After that they hold their values
//   until the next accept.
//   The FSM state is held in the enum register 'state'.

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef NIBBLE_SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic             sub_eff;

`ifdef NIBBLE_SERIAL_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  // 4-bit ripple slice on the low nibble of the operand shift registers.
  // The carries are unrolled so that c3 (the carry into bit 3) is visible.
  // The overflow flag needs c3.
  logic [3:0] sl_g;
  logic [3:0] sl_p;
  logic       sl_c1;
  logic       sl_c2;
  logic       sl_c3;
  logic       sl_c4;
  logic [3:0] sl_sum;

  assign sl_g   = a_sr[3:0] & b_sr[3:0];
  assign sl_p   = a_sr[3:0] ^ b_sr[3:0];
  assign sl_c1  = sl_g[0] | (sl_p[0] & carry);
  assign sl_c2  = sl_g[1] | (sl_p[1] & sl_c1);
  assign sl_c3  = sl_g[2] | (sl_p[2] & sl_c2);
  assign sl_c4  = sl_g[3] | (sl_p[3] & sl_c3);
  assign sl_sum = sl_p ^ {sl_c3, sl_c2, sl_c1, carry};

  assign start_ready  = (state == IDLE);
  assign result_valid = (state == DONE);
  assign busy         = (state != IDLE);
  assign sum          = res;

  // Sequencer: accept operands, run one slice pass per edge, hold result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      carry    <= 1'b0;
      a_sr     <= '0;
      b_sr     <= '0;
      res      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_sr     <= a;
            b_sr     <= b ^ {WIDTH{sub_eff}};
            carry    <= sub_eff;
            res      <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            cnt      <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          res   <= {sl_sum, res[WIDTH-1:4]};
          a_sr  <= a_sr >> 4;
          b_sr  <= b_sr >> 4;
          carry <= sl_c4;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(NIBBLES - 1)) begin
            carryout <= sl_c4;
            overflow <= sl_c4 ^ sl_c3;
            state    <= DONE;
          end
        end
        DONE: begin
          if (result_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
